ahb_lite_master: RTL
====================

Name: ahb_lite_master

Overview:
- Single-channel AHB-Lite master sitting directly upstream of the SRAM controller top. It drives that controller's htrans/hsize/hburst/hwrite/haddr/hwdata and consumes its hready_out/hresp/hrdata.
- Converts one local command (address, size, length, direction) into a pipelined NONSEQ/SEQ incrementing burst.
- Pulls write data from a show-ahead source and returns read data as a valid-qualified stream.

Parameters:
- MAX_LEN, 16, maximum beats per command. Legal lengths are 1..MAX_LEN; the cmd_len width is 5.

Ports:
- hclk  in  1  clock
- hrstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command is accepted on cmd_valid&&cmd_ready
- cmd_addr  in  32  start byte address
- cmd_write  in  1  1=write, 0=read
- cmd_size  in  3  hsize value; legal values 0..2
- cmd_len  in  5  beat count, 1..16
- wd_pop  out  1  pulse: consume wd_data this cycle
- wd_data  in  32  write data, valid whenever wd_pop is high (show-ahead, never empty mid-command)
- rd_valid  out  1  read beat completed
- rd_data  out  32  hrdata captured at that completion
- done  out  1  one-cycle pulse at command end
- err  out  1  qualifies done: ERROR response received or command rejected
- htrans  out  2  IDLE 00, NONSEQ 10, SEQ 11 (BUSY is never issued)
- hsize  out  3  registered from cmd_size
- hburst  out  3  burst encoding (see Behaviour)
- hwrite  out  1  transfer direction
- haddr  out  32  transfer address
- hwdata  out  32  registered write data
- hready  in  1  bus ready (the slave's hready_out)
- hresp  in  2  00 OKAY, 01 ERROR
- hrdata  in  32  read data

Behaviour:
- Reset values: all outputs 0; htrans=IDLE; cmd_ready=1.
- Reset is asynchronous at any time, including mid-burst: state returns to IDLE; the slave-side effect of a partial burst is not recovered.

Command acceptance:
- On acceptance, cmd fields are latched and the block checks the command.
- The command is rejected if cmd_len==0, cmd_len>MAX_LEN, cmd_size>2, cmd_addr is not aligned to 1<<cmd_size, or the burst crosses a 1KB boundary (cmd_addr[9:0] + cmd_len<<cmd_size > 1024).
- A rejected command produces no bus activity: done=1 and err=1 on the next cycle, then IDLE.

hburst mapping:
- len 1 -> SINGLE 000; 4 -> INCR4 011; 8 -> INCR8 101; 16 -> INCR16 111; any other length -> INCR 001.

State machine:
- IDLE -> ADDR -> DATA -> IDLE, plus ERR.
- ADDR: htrans=NONSEQ for the first beat, SEQ for later beats.
  - An address phase is accepted when hready=1.
  - On acceptance: haddr += 1<<size, issue counter increments, and for writes wd_pop=1 in the same cycle, with hwdata <= wd_data registered for that beat's data phase.
  - After the final beat's address is accepted, htrans=IDLE and the block moves to DATA.
- Data phase: completes when hready=1 in the cycle after address acceptance or later.
  - Completion counter increments.
  - For reads, rd_valid=1 and rd_data=hrdata in the same completion cycle, registered to the output one cycle later. rd_valid/rd_data are registered outputs.
- DATA: waits for the last completion, then pulses done=1 with err=0 and returns to IDLE.
- Address and data phases overlap:
  - Back-to-back beats with a zero-wait slave give one beat per cycle.
  - Latency: cmd accept -> first NONSEQ is 1 cycle; done comes 1 cycle after the last data completion.
- hready=0 holds htrans, haddr, hwdata and the counters stable. No wd_pop is issued while stalled.

Error handling:
- hresp=ERROR with hready=0 (first error cycle): the next htrans is IDLE, cancelling any pending address phase, and the block enters ERR.
- ERR: when hready=1 (second error cycle), done=1 and err=1, then IDLE. No further beats, pops or rd_valid occur.
- If the slave never errors (the SRAM controller returns OKAY), ERR is never reached.

Test Plan:
1. Write len=4, size=2, addr=0x100, wd_data 0xA0..0xA3; zero-wait slave.
   - Required: NONSEQ then 3 SEQ on consecutive cycles; haddr 0x100/104/108/10C; hburst=011; 4 wd_pops; done 1 cycle after the last data phase, err=0.
2. Read back the same range (len=4).
   - Required: 4 rd_valid pulses with data 0xA0..0xA3 in order; done err=0.
3. Byte write, len=3, size=0, addr=0x203.
   - Required: hburst=001; haddr 0x203/204/205; hsize=000.
4. Stall: slave drives hready=0 for 2 cycles mid-burst.
   - Required: htrans/haddr/hwdata held, no wd_pop during the stall, burst resumes intact.
5. Rejects: cmd_addr=0x3F8 with len=4, size=2 (crosses 1KB), then cmd_len=0.
   - Required: each gives done=1, err=1 one cycle after acceptance; htrans stays IDLE.
6. Error injection: ERROR response on beat 2 of an 8-beat read.
   - Required: htrans=IDLE in the 2nd error cycle; done=1, err=1; exactly 1 rd_valid.
   - Then assert hrstn low mid-burst: outputs return immediately to reset values.

Source files
------------

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - AHB-Lite burst master: one local command becomes a pipelined INCR burst
module ahb_lite_master #(
   parameter int MAX_LEN = 16
) (
   input  logic        hclk,
   input  logic        hrstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic        cmd_write,
   input  logic [2:0]  cmd_size,
   input  logic [4:0]  cmd_len,
   output logic        wd_pop,
   input  logic [31:0] wd_data,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        done,
   output logic        err,
   output logic [1:0]  htrans,
   output logic [2:0]  hsize,
   output logic [2:0]  hburst,
   output logic        hwrite,
   output logic [31:0] haddr,
   output logic [31:0] hwdata,
   input  logic        hready,
   input  logic [1:0]  hresp,
   input  logic [31:0] hrdata
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [1:0] RESP_ERR  = 2'b01;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

   state_t      state_q, state_d;
   logic [1:0]  htrans_q, htrans_d;
   logic [31:0] haddr_q, haddr_d;
   logic [2:0]  hsize_q, hsize_d;
   logic [2:0]  hburst_q, hburst_d;
   logic        hwrite_q, hwrite_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic [4:0]  len_q, len_d;
   logic [4:0]  issue_q, issue_d;
   logic [4:0]  comp_q, comp_d;
   logic        dphase_q, dphase_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        rd_valid_q, rd_valid_d;
   logic [31:0] rd_data_q, rd_data_d;

   logic [11:0] span;
   logic        misalign;
   logic        cmd_bad;
   logic [2:0]  burst_enc;
   logic [31:0] incr;

   // Byte span from the 1KB page base; anything past 1024 leaves the page.
   always_comb begin
      span     = {2'b00, cmd_addr[9:0]} + ({7'd0, cmd_len} << cmd_size[1:0]);
      misalign = (cmd_size == 3'd1 && cmd_addr[0]) ||
                 (cmd_size == 3'd2 && cmd_addr[1:0] != 2'b00);
      cmd_bad  = (cmd_len == 5'd0) || (int'(cmd_len) > MAX_LEN) ||
                 (cmd_size > 3'd2) || misalign || (span > 12'd1024);
      case (cmd_len)
         5'd1:    burst_enc = 3'b000;
         5'd4:    burst_enc = 3'b011;
         5'd8:    burst_enc = 3'b101;
         5'd16:   burst_enc = 3'b111;
         default: burst_enc = 3'b001;
      endcase
      incr = 32'd1 << hsize_q[1:0];
   end

   always_comb begin
      state_d    = state_q;
      htrans_d   = htrans_q;
      haddr_d    = haddr_q;
      hsize_d    = hsize_q;
      hburst_d   = hburst_q;
      hwrite_d   = hwrite_q;
      hwdata_d   = hwdata_q;
      len_d      = len_q;
      issue_d    = issue_q;
      comp_d     = comp_q;
      dphase_d   = dphase_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      wd_pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_bad) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  state_d  = S_ADDR;
                  htrans_d = TR_NONSEQ;
                  haddr_d  = cmd_addr;
                  hsize_d  = cmd_size;
                  hburst_d = burst_enc;
                  hwrite_d = cmd_write;
                  len_d    = cmd_len;
                  issue_d  = 5'd0;
                  comp_d   = 5'd0;
                  dphase_d = 1'b0;
               end
            end
         end
         S_ADDR, S_DATA: begin
            if (dphase_q && !hready && hresp == RESP_ERR) begin
               // First error cycle: cancel the pending address phase.
               htrans_d = TR_IDLE;
               state_d  = S_ERR;
            end else if (hready) begin
               dphase_d = 1'b0;
               if (dphase_q) begin
                  comp_d = comp_q + 5'd1;
                  if (!hwrite_q) begin
                     rd_valid_d = 1'b1;
                     rd_data_d  = hrdata;
                  end
                  if (state_q == S_DATA && comp_q + 5'd1 == len_q) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end
               if (state_q == S_ADDR) begin
                  dphase_d = 1'b1;
                  haddr_d  = haddr_q + incr;
                  issue_d  = issue_q + 5'd1;
                  if (hwrite_q) begin
                     wd_pop   = 1'b1;
                     hwdata_d = wd_data;
                  end
                  if (issue_q + 5'd1 == len_q) begin
                     htrans_d = TR_IDLE;
                     state_d  = S_DATA;
                  end else begin
                     htrans_d = TR_SEQ;
                  end
               end
            end
         end
         S_ERR: begin
            if (hready) begin
               done_d   = 1'b1;
               err_d    = 1'b1;
               dphase_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         state_q    <= S_IDLE;
         htrans_q   <= TR_IDLE;
         haddr_q    <= 32'd0;
         hsize_q    <= 3'd0;
         hburst_q   <= 3'd0;
         hwrite_q   <= 1'b0;
         hwdata_q   <= 32'd0;
         len_q      <= 5'd0;
         issue_q    <= 5'd0;
         comp_q     <= 5'd0;
         dphase_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         htrans_q   <= htrans_d;
         haddr_q    <= haddr_d;
         hsize_q    <= hsize_d;
         hburst_q   <= hburst_d;
         hwrite_q   <= hwrite_d;
         hwdata_q   <= hwdata_d;
         len_q      <= len_d;
         issue_q    <= issue_d;
         comp_q     <= comp_d;
         dphase_q   <= dphase_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign htrans    = htrans_q;
   assign haddr     = haddr_q;
   assign hsize     = hsize_q;
   assign hburst    = hburst_q;
   assign hwrite    = hwrite_q;
   assign hwdata    = hwdata_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

endmodule
